dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Byte-granular store buffer between the single-cycle core's data ports and the data SRAM.
- Accepts core stores in one cycle and drains them in FIFO order to the SRAM over a valid/ready write port.
- Forwards buffered bytes into core loads so the core always sees the architecturally latest memory value.
- Provides `stall` so the core can hold a store when the buffer is full.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- dwaddr  in  32  core store byte address.
- dwdata  in  32  core store data, right-justified.
- dwsize  in  2  store size: 0 byte, 1 half, 2 word, 3 illegal.
- dwe  in  1  core store request.
- stall  out  1  store request not accepted this cycle; core holds request.
- misaligned  out  1  current store/load is misaligned or has an illegal size.
- draddr  in  32  core load byte address.
- drsize  in  2  load size, same encoding as dwsize.
- drdata  out  32  load result, zero-extended.
- mem_raddr  out  32  {draddr[31:2],2'b00} to SRAM read port.
- mem_rdata  in  32  SRAM word at mem_raddr (combinational).
- mem_we  out  1  head entry valid.
- mem_waddr  out  32  head word address, low 2 bits = 0.
- mem_wdata  out  32  head data, lane-aligned.
- mem_wbe  out  4  head byte enables.
- mem_wready  in  1  SRAM accepts the write this cycle.
- empty  out  1  no buffered stores.

Behaviour:
- Entry contents: word address [31:2], 4-bit byte mask, 32-bit lane-aligned data.
- Circular FIFO state: head, tail (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (async assert, sync-safe release):
  - head, tail, count = 0; all masks = 0.
  - mem_we = 0, stall = 0, empty = 1.
  - Buffered stores are discarded if reset asserts mid-operation.
- Misalignment rule:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]!=0 is misaligned;
  - size 3 is illegal.
  - misaligned is combinational = (dwe & bad store) | bad load.
  - A bad store is dropped (no enqueue, no stall); a bad load returns drdata = 0.
- Enqueue: when dwe & !bad & count<DEPTH (and not coalesced, see Optional Feature), write the entry at tail; tail+1.
  - Byte mask: 0001<<a[1:0], 0011<<a[1:0], or 1111.
  - Data shifted left by 8*a[1:0].
- stall is combinational = dwe & !bad & (count==DEPTH). It is based on registered count only; a same-cycle drain does not free a slot.
- Drain: mem_we=(count!=0); mem_* outputs come directly from the head entry registers. On mem_we & mem_wready, head+1.
- Counter update:
  - enqueue and drain in the same cycle: count unchanged;
  - enqueue only: count+1;
  - drain only: count-1.
- Latency: a store is visible to loads (via forwarding) in the cycle after acceptance and reaches the SRAM no earlier than one cycle after acceptance.
- Load forwarding (combinational):
  - Start from mem_rdata.
  - For each valid entry from oldest to youngest whose word address matches draddr[31:2], overwrite the bytes set in its mask.
  - Extract bytes by drsize and draddr[1:0], then zero-extend.
  - Same-cycle enqueue is not forwarded.
  - The head entry being drained in the current cycle is still forwarded (SRAM updates at the edge).
- empty = (count==0).

Optional Feature:
- Macro STB_COALESCE_EN.
- Defined: if dwe & !bad, count!=0, and the youngest entry (tail-1) matches the word address and is not simultaneously being drained, merge into it.
  - OR the mask into the entry; replace data bytes under the new mask.
  - No allocation, and no stall even when full.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset with stores buffered (count=3) -> count=0, mem_we=0, empty=1 immediately (async); stores lost.
- sw 0x1000=0xDEADBEEF, mem_wready=0, then lw 0x1000 -> drdata=0xDEADBEEF; then mem_wready=1 -> mem_wbe=4'hF, mem_wdata=0xDEADBEEF, mem_waddr=0x1000.
- mem_rdata=0x11223344 at 0x2000; sb 0x2001=0xAA; sh 0x2002=0xBBCC; lw 0x2000 -> 0xBBCCAA44; lbu 0x2001 -> 0x000000AA.
- mem_wready=0, five sw to distinct words with DEPTH=4 -> four accepted, stall=1 on fifth; one drain cycle frees a slot; the held store is accepted next cycle.
- sh 0x3001 -> misaligned=1, stall=0, count unchanged; lw 0x3002 -> misaligned=1, drdata=0.
- With STB_COALESCE_EN: buffer full, sb 0x4000=0x11 then sb 0x4001=0x22 to the youngest word -> stall=0, entry mask=0011, data lanes 0x2211; without the macro the second store stalls.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// -----------------------------------------------------------------------------
// dmem_store_buffer
//
// Purpose:
//   Byte-granular store buffer that sits between a single-cycle core's data
//   ports and the data SRAM. Core stores are accepted in one cycle into a
//   circular FIFO and drained in order to the SRAM write port. Core loads see
//   the architecturally latest value: the SRAM word is overlaid with every
//   matching buffered entry, oldest first, so the youngest bytes win.
//
// Optional feature (macro STB_COALESCE_EN):
//   When defined, a store that hits the word of the youngest entry (and that
//   entry is not leaving through the write port this cycle) is merged into it
//   instead of allocating a new entry. Merging never stalls, even when full.
//   When undefined, every accepted store allocates its own entry.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   PTR_W  pointer width, must equal log2(DEPTH)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous active-low reset (0 = reset)
//   dwaddr      core store byte address
//   dwdata      core store data, right-justified
//   dwsize      store size: 0 byte, 1 half, 2 word, 3 illegal
//   dwe         core store request
//   stall       store not accepted this cycle, core holds the request
//   misaligned  current store (when dwe) or load is misaligned / illegal size
//   draddr      core load byte address
//   drsize      load size, same encoding as dwsize
//   drdata      load result, zero-extended
//   mem_raddr   word-aligned load address to the SRAM read port
//   mem_rdata   SRAM word at mem_raddr (combinational)
//   mem_we      head entry valid (write request)
//   mem_waddr   head word address, low 2 bits zero
//   mem_wdata   head data, lane-aligned
//   mem_wbe     head byte enables
//   mem_wready  SRAM accepts the write this cycle
//   empty       no buffered stores
//
// Write port handshake: mem_we is the valid, mem_wready the ready. A write
// transfers on a rising edge where both are high; mem_we and the mem_w*
// payload depend only on registered state and stay stable until transfer.
// -----------------------------------------------------------------------------
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dwaddr,
  input  logic [31:0] dwdata,
  input  logic [1:0]  dwsize,
  input  logic        dwe,
  output logic        stall,
  output logic        misaligned,
  input  logic [31:0] draddr,
  input  logic [1:0]  drsize,
  output logic [31:0] drdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbe,
  input  logic        mem_wready,
  output logic        empty
);

  // Entry storage
  logic [29:0]      r_addr [DEPTH];
  logic [3:0]       r_mask [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_st_bad;
  logic             w_ld_bad;
  logic [3:0]       w_st_mask;
  logic [31:0]      w_st_data;
  logic             w_full;
  logic             w_drain;
  logic             w_coal;
  logic             w_enq;
  logic [31:0]      w_fwd_word;
  logic [31:0]      w_ld_shift;
  logic [PTR_W-1:0] w_idx;

  function automatic logic size_bad(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  assign w_st_bad   = size_bad(dwsize, dwaddr[1:0]);
  assign w_ld_bad   = size_bad(drsize, draddr[1:0]);
  assign misaligned = (dwe & w_st_bad) | w_ld_bad;

  // Lane placement of the incoming store
  always_comb begin
    case (dwsize)
      2'd0:    w_st_mask = 4'b0001 << dwaddr[1:0];
      2'd1:    w_st_mask = 4'b0011 << dwaddr[1:0];
      default: w_st_mask = 4'b1111;
    endcase
  end
  assign w_st_data = dwdata << {dwaddr[1:0], 3'b000};

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign mem_we  = ~empty;
  assign w_drain = mem_we & mem_wready;

`ifdef STB_COALESCE_EN
  logic [PTR_W-1:0] w_tail_m1;
  logic [31:0]      w_lane_mask;
  logic [31:0]      w_merged;

  assign w_tail_m1   = r_tail - PTR_W'(1);
  assign w_lane_mask = {{8{w_st_mask[3]}}, {8{w_st_mask[2]}},
                        {8{w_st_mask[1]}}, {8{w_st_mask[0]}}};
  assign w_merged    = (r_data[w_tail_m1] & ~w_lane_mask) | (w_st_data & w_lane_mask);
  // The youngest entry is also the head only when count==1; if it is
  // transferring this cycle a merge would be lost, so allocate instead.
  assign w_coal = dwe & ~w_st_bad & ~empty &
                  (r_addr[w_tail_m1] == dwaddr[31:2]) &
                  ~(w_drain & (r_count == (PTR_W+1)'(1)));
`else
  assign w_coal = 1'b0;
`endif

  // Full is judged on the registered count: a drain in the same cycle does
  // not free a slot until the next cycle.
  assign stall = dwe & ~w_st_bad & w_full & ~w_coal;
  assign w_enq = dwe & ~w_st_bad & ~w_full & ~w_coal;

  // Write port comes straight from head registers
  assign mem_waddr = {r_addr[r_head], 2'b00};
  assign mem_wdata = r_data[r_head];
  assign mem_wbe   = r_mask[r_head];
  assign mem_raddr = {draddr[31:2], 2'b00};

  // Load forwarding: overlay valid matching entries oldest to youngest.
  // The head is still overlaid while draining since the SRAM only updates
  // at the edge.
  always_comb begin
    w_fwd_word = mem_rdata;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) && (r_addr[w_idx] == draddr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mask[w_idx][b]) begin
            w_fwd_word[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign w_ld_shift = w_fwd_word >> {draddr[1:0], 3'b000};

  always_comb begin
    drdata = '0;
    if (!w_ld_bad) begin
      case (drsize)
        2'd0:    drdata = {24'b0, w_ld_shift[7:0]};
        2'd1:    drdata = {16'b0, w_ld_shift[15:0]};
        default: drdata = w_ld_shift;
      endcase
    end
  end

  // FIFO state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= dwaddr[31:2];
        r_mask[r_tail] <= w_st_mask;
        r_data[r_tail] <= w_st_data;
        r_tail         <= r_tail + PTR_W'(1);
      end
`ifdef STB_COALESCE_EN
      if (w_coal) begin
        r_mask[w_tail_m1] <= r_mask[w_tail_m1] | w_st_mask;
        r_data[w_tail_m1] <= w_merged;
      end
`endif
      if (w_drain) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] dwaddr, dwdata;
  logic [1:0]  dwsize;
  logic        dwe;
  logic        stall, misaligned;
  logic [31:0] draddr;
  logic [1:0]  drsize;
  logic [31:0] drdata, mem_raddr, mem_rdata;
  logic        mem_we;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wbe;
  logic        mem_wready;
  logic        empty;

  dmem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .dwaddr(dwaddr), .dwdata(dwdata), .dwsize(dwsize), .dwe(dwe),
    .stall(stall), .misaligned(misaligned),
    .draddr(draddr), .drsize(drsize), .drdata(drdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wbe(mem_wbe), .mem_wready(mem_wready), .empty(empty)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [67:0] exp_q[$];   // {waddr, wdata, wbe}
  logic [64:0] ld_q[$];    // {raddr, misaligned, drdata}
  logic        ld_chk;
  logic [67:0] wr_e;
  logic [64:0] ld_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: write port transfers and flagged load cycles
  always @(negedge clk) begin
    if (reset && mem_we && mem_wready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr=%h data=%h be=%h expected none",
                 mem_waddr, mem_wdata, mem_wbe);
      end else begin
        wr_e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata, mem_wbe} !== wr_e) begin
          n_err++;
          $display("FAIL wr_port: got addr=%h data=%h be=%h expected addr=%h data=%h be=%h",
                   mem_waddr, mem_wdata, mem_wbe, wr_e[67:36], wr_e[35:4], wr_e[3:0]);
        end
      end
    end
    if (ld_chk) begin
      n_cmp++;
      if (ld_q.size() == 0) begin
        n_err++;
        $display("FAIL ld_noexp: got data=%h expected queued entry", drdata);
      end else begin
        ld_e = ld_q.pop_front();
        if ({mem_raddr, misaligned, drdata} !== ld_e) begin
          n_err++;
          $display("FAIL load: got raddr=%h mis=%b data=%h expected raddr=%h mis=%b data=%h",
                   mem_raddr, misaligned, drdata, ld_e[64:33], ld_e[32], ld_e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    dwe = 1'b1; dwaddr = a; dwdata = d; dwsize = sz;
    @(negedge clk);
    chk("stall_on_accept", {31'b0, stall}, 32'd0);
    step();
    dwe = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd,
                      input logic mis, input logic [31:0] exp);
    draddr = a; drsize = sz; mem_rdata = rd;
    ld_q.push_back({a & 32'hFFFF_FFFC, mis, exp});
    ld_chk = 1'b1;
    step();
    ld_chk = 1'b0;
  endtask

  task automatic drain_all();
    int k;
    k = 0;
    mem_wready = 1'b1;
    while (!empty && k < 20) begin
      step();
      k++;
    end
    chk("drain_done", {31'b0, empty}, 32'd1);
    mem_wready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; dwe = 1'b0; dwaddr = '0; dwdata = '0; dwsize = 2'd0;
    draddr = '0; drsize = 2'd2; mem_rdata = '0; mem_wready = 1'b0; ld_chk = 1'b0;

    // reset state
    #7;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // reset asserted with three stores buffered: they must vanish
    store(32'h0000_0100, 32'h1111_1111, 2'd2);
    store(32'h0000_0104, 32'h2222_2222, 2'd2);
    store(32'h0000_0108, 32'h3333_3333, 2'd2);
    chk("pre_rst_empty", {31'b0, empty}, 32'd0);
    chk("pre_rst_mem_we", {31'b0, mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_empty", {31'b0, empty}, 32'd1);
    chk("async_rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    mem_wready = 1'b1;
    repeat (3) step();
    chk("post_rst_empty", {31'b0, empty}, 32'd1);
    mem_wready = 1'b0;

    // word store forwarded, then drained (forwarded during drain too)
    store(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    push_wr(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    load(32'h0000_1000, 2'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
    mem_wready = 1'b1;
    load(32'h0000_1000, 2'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
    mem_wready = 1'b0;
    chk("sw_drained_empty", {31'b0, empty}, 32'd1);

    // byte + half merged over SRAM word
    store(32'h0000_2001, 32'h0000_00AA, 2'd0);
    push_wr(32'h0000_2000, 32'h0000_AA00, 4'h2);
    store(32'h0000_2002, 32'h0000_BBCC, 2'd1);
    push_wr(32'h0000_2000, 32'hBBCC_0000, 4'hC);
    load(32'h0000_2000, 2'd2, 32'h1122_3344, 1'b0, 32'hBBCC_AA44);
    load(32'h0000_2001, 2'd0, 32'h1122_3344, 1'b0, 32'h0000_00AA);
    load(32'h0000_2002, 2'd1, 32'h1122_3344, 1'b0, 32'h0000_BBCC);
    load(32'h0000_2000, 2'd0, 32'h1122_3344, 1'b0, 32'h0000_0044);
    load(32'h0000_2004, 2'd2, 32'h5566_7788, 1'b0, 32'h5566_7788);
    drain_all();

    // full buffer: fifth store stalls until a drain frees a slot
    for (int i = 0; i < 4; i++) begin
      store(32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2);
      push_wr(32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    dwe = 1'b1; dwaddr = 32'h0000_5010; dwdata = 32'hA000_0004; dwsize = 2'd2;
    @(negedge clk);
    chk("stall_full", {31'b0, stall}, 32'd1);
    step();
    mem_wready = 1'b1;
    @(negedge clk);
    chk("stall_same_cycle_drain", {31'b0, stall}, 32'd1);
    step();
    mem_wready = 1'b0;
    @(negedge clk);
    chk("stall_freed", {31'b0, stall}, 32'd0);
    push_wr(32'h0000_5010, 32'hA000_0004, 4'hF);
    step();
    dwe = 1'b0;
    drain_all();

    // misaligned / illegal stores dropped, bad loads return zero
    dwe = 1'b1; dwaddr = 32'h0000_3001; dwdata = 32'h0000_1234; dwsize = 2'd1;
    @(negedge clk);
    chk("mis_sh_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_sh_stall", {31'b0, stall}, 32'd0);
    step();
    dwaddr = 32'h0000_3000; dwsize = 2'd3;
    @(negedge clk);
    chk("illegal_size_flag", {31'b0, misaligned}, 32'd1);
    step();
    dwe = 1'b0;
    chk("mis_not_enqueued", {31'b0, empty}, 32'd1);
    load(32'h0000_3002, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'h0);
    load(32'h0000_3003, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    load(32'h0000_3002, 2'd1, 32'hAABB_CCDD, 1'b0, 32'h0000_AABB);

    // second byte to the youngest word while full
    store(32'h0000_6000, 32'h6000_0000, 2'd2);
    push_wr(32'h0000_6000, 32'h6000_0000, 4'hF);
    store(32'h0000_6004, 32'h6000_0004, 2'd2);
    push_wr(32'h0000_6004, 32'h6000_0004, 4'hF);
    store(32'h0000_6008, 32'h6000_0008, 2'd2);
    push_wr(32'h0000_6008, 32'h6000_0008, 4'hF);
    store(32'h0000_4000, 32'h0000_0011, 2'd0);
    dwe = 1'b1; dwaddr = 32'h0000_4001; dwdata = 32'h0000_0022; dwsize = 2'd0;
`ifdef STB_COALESCE_EN
    @(negedge clk);
    chk("coal_no_stall", {31'b0, stall}, 32'd0);
    push_wr(32'h0000_4000, 32'h0000_2211, 4'h3);
    step();
    dwe = 1'b0;
`else
    push_wr(32'h0000_4000, 32'h0000_0011, 4'h1);
    @(negedge clk);
    chk("nocoal_stall", {31'b0, stall}, 32'd1);
    step();
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    @(negedge clk);
    chk("nocoal_freed", {31'b0, stall}, 32'd0);
    push_wr(32'h0000_4000, 32'h0000_2200, 4'h2);
    step();
    dwe = 1'b0;
`endif
    load(32'h0000_4000, 2'd2, 32'h9999_9999, 1'b0, 32'h9999_2211);
    drain_all();

    repeat (2) step();
    chk("wr_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
